// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg
//   Shared definitions for the run monitor: the 3-bit state encoding of the
//   sequencing FSM and the default run-cycle limit.
package run_monitor_pkg;

  localparam logic [2:0] ENC_IDLE = 3'd0;
  localparam logic [2:0] ENC_HOLD = 3'd1;
  localparam logic [2:0] ENC_RUN  = 3'd2;
  localparam logic [2:0] ENC_DUMP = 3'd3;
  localparam logic [2:0] ENC_DONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = ENC_IDLE,
    ST_HOLD = ENC_HOLD,
    ST_RUN  = ENC_RUN,
    ST_DUMP = ENC_DUMP,
    ST_DONE = ENC_DONE
  } state_t;

  localparam int DEFAULT_MAX_CYCLES = 1600;

endpackage

// File: rtl/run_monitor_halt_detector.sv
// halt_detector
//   Watches the core PC while enabled and flags a halt once HALT_STABLE
//   consecutive samples are identical (a PC self-loop).
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset
//   enable - sample pc this cycle (core is running)
//   clear  - forget history before a new run
//   pc     - current core PC
//   halt   - combinational: this cycle's sample completes the equal run
module halt_detector
  import run_monitor_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int HALT_STABLE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [ADDR_W-1:0] pc,
  output logic              halt
);

  // stable counts equalities, so it never needs to exceed HALT_STABLE-1
  localparam int SW = (HALT_STABLE > 2) ? $clog2(HALT_STABLE) : 1;

  logic [ADDR_W-1:0] prev_pc;
  logic              prev_valid;
  logic [SW-1:0]     stable;
  logic              match;

  // The first sample of a run has nothing to compare against.
  assign match = enable && prev_valid && (pc == prev_pc);
  assign halt  = match && (stable == SW'(HALT_STABLE - 2));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      stable     <= '0;
    end else if (clear) begin
      prev_valid <= 1'b0;
      stable     <= '0;
    end else if (enable) begin
      prev_pc    <= pc;
      prev_valid <= 1'b1;
      if (!match) begin
        stable <= '0;
      end else if (stable != SW'(HALT_STABLE - 1)) begin
        stable <= stable + 1'b1;
      end
    end
  end

endmodule

// File: rtl/run_monitor.sv
// run_monitor
//   Run controller for the single-cycle RISC-V core: holds the core in reset
//   for RESET_CYCLES after start, runs it while counting cycles, stops on a
//   PC self-loop or after MAX_CYCLES, then freezes the core and streams the
//   register file out over a valid/ready port.
// Ports:
//   clock, reset (async active-low), start (pulse)
//   core_reset, core_en            - core control
//   pc                             - core PC
//   rf_rd_addr, rf_rd_data         - register-file debug read (async data)
//   dump_valid, dump_ready,
//   dump_index, dump_data          - register dump stream
//   done, timeout, cycle_count     - run status
// Optional (macro RUN_MONITOR_CHECK_EN):
//   check_reg, check_value, pass, fail - compare one dumped register
//
// state | meaning
// IDLE  | core held in reset, waiting for start
// HOLD  | core reset asserted with clock enabled for RESET_CYCLES
// RUN   | core running, cycle counter and halt detector active
// DUMP  | core frozen, register file streamed beat by beat
// DONE  | dump finished, waiting for start to re-run
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int REG_AW       = 5,
  parameter int NUM_REGS     = 32,
  parameter int RESET_CYCLES = 2,
  parameter int HALT_STABLE  = 4,
  parameter int MAX_CYCLES   = DEFAULT_MAX_CYCLES,
  parameter int CNT_W        = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              core_reset,
  output logic              core_en,
  input  logic [ADDR_W-1:0] pc,
  output logic [REG_AW-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [REG_AW-1:0] dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic              done,
  output logic              timeout,
`ifdef RUN_MONITOR_CHECK_EN
  input  logic [REG_AW-1:0] check_reg,
  input  logic [DATA_W-1:0] check_value,
  output logic              pass,
  output logic              fail,
`endif
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [REG_AW-1:0] idx_nxt;
  logic              timeout_nxt;
  logic              start_acc;
  logic              halt;

  assign rf_rd_addr = dump_index;
  assign dump_data  = rf_rd_data;

  halt_detector #(
    .ADDR_W      (ADDR_W),
    .HALT_STABLE (HALT_STABLE)
  ) u_halt (
    .clock  (clock),
    .reset  (reset),
    .enable (state == ST_RUN),
    .clear  (start_acc),
    .pc     (pc),
    .halt   (halt)
  );

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    cnt_nxt     = cycle_count;
    idx_nxt     = dump_index;
    timeout_nxt = timeout;
    start_acc   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt   = ST_HOLD;
          hold_nxt    = HOLD_W'(RESET_CYCLES - 1);
          cnt_nxt     = '0;
          timeout_nxt = 1'b0;
          start_acc   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == '0) begin
          state_nxt = ST_RUN;
        end else begin
          hold_nxt = hold_cnt - 1'b1;
        end
      end
      ST_RUN: begin
        if (cycle_count != '1) begin
          cnt_nxt = cycle_count + 1'b1;
        end
        // halt has priority when both land on the same cycle
        if (halt) begin
          state_nxt = ST_DUMP;
        end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
          state_nxt   = ST_DUMP;
          timeout_nxt = 1'b1;
        end
      end
      ST_DUMP: begin
        if (dump_ready) begin
          if (dump_index == REG_AW'(NUM_REGS - 1)) begin
            state_nxt = ST_DONE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = dump_index + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they change on
  // the same edge as the state itself.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      cycle_count <= '0;
      dump_index  <= '0;
      timeout     <= 1'b0;
      core_reset  <= 1'b1;
      core_en     <= 1'b0;
      dump_valid  <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      cycle_count <= cnt_nxt;
      dump_index  <= idx_nxt;
      timeout     <= timeout_nxt;
      core_reset  <= (state_nxt == ST_IDLE) || (state_nxt == ST_HOLD);
      core_en     <= (state_nxt == ST_HOLD) || (state_nxt == ST_RUN);
      dump_valid  <= (state_nxt == ST_DUMP);
      done        <= (state_nxt == ST_DONE);
    end
  end

`ifdef RUN_MONITOR_CHECK_EN
  logic cmp_ok;
  logic beat_hit;
  logic beat_ok;

  assign beat_hit = (state == ST_DUMP) && dump_ready && (dump_index == check_reg);
  // The checked register may be the final beat, so fold in the live compare.
  assign beat_ok  = beat_hit ? (rf_rd_data == check_value) : cmp_ok;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmp_ok <= 1'b0;
      pass   <= 1'b0;
      fail   <= 1'b0;
    end else if (start_acc) begin
      cmp_ok <= 1'b0;
      pass   <= 1'b0;
      fail   <= 1'b0;
    end else begin
      if (beat_hit) begin
        cmp_ok <= (rf_rd_data == check_value);
      end
      if ((state == ST_DUMP) && (state_nxt == ST_DONE)) begin
        pass <= beat_ok && !timeout;
        fail <= !(beat_ok && !timeout);
      end
    end
  end
`endif

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
- Synthesizable run controller for the single-cycle RISC-V core.
- Sequencing:
  - Holds the core in reset for a set number of cycles, then releases it.
  - Counts executed cycles.
  - Detects program halt (PC self-loop) or a cycle-limit timeout.
  - Freezes the core and streams out the register file over a valid/ready port.
- Sits beside `top`. It replaces fixed-delay reset/run/dump sequencing with a parametrised, handshaked block usable on FPGA and in simulation.

Parameters:
- DATA_W, 32, register/data width.
- ADDR_W, 32, PC width.
- REG_AW, 5, register index width.
- NUM_REGS, 32, registers dumped (≤ 2^REG_AW).
- RESET_CYCLES, 2, cycles core_reset is held after start (≥ 1).
- HALT_STABLE, 4, consecutive equal-PC comparisons that declare halt (≥ 2).
- MAX_CYCLES, 1600, RUN cycles before timeout.
- CNT_W, 32, cycle counter width.

Ports:
- clock, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: single-cycle pulse that begins a run.
- core_reset, out, 1: active-high reset to core.
- core_en, out, 1: core clock enable; 0 freezes architectural state.
- pc, in, ADDR_W: core current PC.
- rf_rd_addr, out, REG_AW: register-file debug read address.
- rf_rd_data, in, DATA_W: asynchronous read data for rf_rd_addr.
- dump_valid, out, 1: dump beat valid.
- dump_ready, in, 1: consumer ready.
- dump_index, out, REG_AW: register index of current beat.
- dump_data, out, DATA_W: register value of current beat.
- done, out, 1: dump complete.
- timeout, out, 1: run ended by MAX_CYCLES, not halt.
- cycle_count, out, CNT_W: RUN cycles elapsed.

Behaviour:
- Reset values (immediate, asynchronous on reset=0):
  - state=IDLE, core_reset=1, core_en=0.
  - dump_valid=0, dump_index=0, done=0, timeout=0, cycle_count=0.
  - Internal hold counter and stable counter = 0.
- State machine: IDLE, HOLD, RUN, DUMP, DONE. All outputs are registered except dump_data (= rf_rd_data) and rf_rd_addr (= dump_index).
- IDLE:
  - core_reset=1, core_en=0.
  - start=1 → HOLD; clears cycle_count, timeout, done, stable counter.
- HOLD:
  - core_reset=1, core_en=1.
  - After exactly RESET_CYCLES cycles in HOLD → RUN. core_reset falls on the same edge.
- RUN:
  - core_reset=0, core_en=1.
  - cycle_count += 1 every cycle; saturates at all-ones.
  - Each cycle, compare pc with the registered previous pc: equal → stable+1, else stable=0.
  - Halt when stable reaches HALT_STABLE-1, i.e. HALT_STABLE equal consecutive samples.
  - Timeout when cycle_count reaches MAX_CYCLES without halt.
  - Either event → DUMP on the next edge. timeout=1 only for the timeout path.
  - If halt and timeout occur in the same cycle, halt wins and timeout=0.
- DUMP:
  - core_en=0; core_reset stays 0, so state is preserved.
  - dump_valid=1 throughout.
  - A beat transfers on dump_valid & dump_ready; dump_index then increments.
  - While dump_ready=0: dump_index and dump_data hold stable. The core is frozen, so rf_rd_data is stable.
  - Transfer at index NUM_REGS-1 → DONE; dump_valid=0 on the same edge. No wrap.
- DONE:
  - done=1, core_en=0, dump_index=0.
  - start=1 → HOLD (re-run): clears done, timeout, cycle_count.
- start is ignored in HOLD, RUN and DUMP.
- Reset mid-operation (any state) returns to the reset values; no partial dump is resumed.
- cycle_count is held (not incremented) outside RUN.

Optional Feature:
- Macro RUN_MONITOR_CHECK_EN.
- Defined:
  - Extra ports: check_reg (in, REG_AW), check_value (in, DATA_W), pass (out, 1), fail (out, 1). pass and fail reset to 0.
  - During DUMP, the beat whose dump_index==check_reg is compared with check_value.
  - On entering DONE: pass=1 if equal and timeout=0; otherwise fail=1.
  - Both clear on start.
- Undefined: the ports and compare logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package run_monitor_pkg: state encoding localparams (IDLE..DONE, 3-bit) and a default MAX_CYCLES constant.
- Sub-module halt_detector:
  - Function: pc register, stable counter, halt output.
  - Ports: clock, reset, enable, clear, pc, halt.
  - Parameters: ADDR_W, HALT_STABLE.

Test Plan:
- fibonacci.vmh loaded into main memory, start pulse, dump_ready=1 → halt detected, timeout=0, beat index 9 = 0x00000015, beat 0 = 0, 32 beats then done=1.
- gcd.vmh, same stimulus → beat index 9 = 0x00000010, done=1, timeout=0.
- Program with no self-loop, MAX_CYCLES=100 → cycle_count=100, timeout=1, dump still produces 32 beats.
- fibonacci with dump_ready toggling 1-0-0-1 pseudo-randomly → indices 0..31 in order, no duplicate or skipped beat, dump_data stable while stalled.
- reset=0 asserted mid-RUN at cycle 50 → core_reset=1 and state=IDLE immediately; after release, a start re-runs fibonacci to the correct x9.
- start pulsed during RUN and DUMP → ignored. start in DONE → new run with cycle_count restarting from 0.
